sipo_deser: RTL and testbench



---
 rtl/sipo_pkg.sv | 30 +++
 rtl/sipo_deser_if.sv | 26 ++
 rtl/sipo_out_stage.sv | 48 ++++
 rtl/sipo_deser.sv | 64 ++++++
 tb/tb_sipo_deser.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared constants, holding-register state encoding and the shift helper
// used by the sipo_deser serial-to-parallel deserializer.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 32'sd4;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Next shift-register value for one accepted bit; bits at and above width are forced to zero.
    function automatic logic [63:0] sipo_shift(
        input logic [63:0] sh,
        input logic        bit_in,
        input logic        msb_first,
        input int          width
    );
        logic [63:0] nxt_s;
        logic [63:0] mask_s;
        mask_s = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
        if (msb_first) begin
            nxt_s = {sh[62:0], bit_in};
        end else begin
            nxt_s = (sh >> 1) | ({63'd0, bit_in} << (width - 32'sd1));
        end
        return nxt_s & mask_s;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel output handshake bundle for sipo_deser.
interface sipo_deser_if import sipo_pkg::*; #(
    parameter int WIDTH = SIPO_WIDTH_DEF
) ();
    localparam int CNT_W = $clog2(WIDTH);

    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic             frame_start;
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic [CNT_W-1:0] bit_cnt;
    logic             sync_err;

    modport master (
        output ser_in, ser_valid, frame_start, par_ready,
        input  ser_ready, par_data, par_valid, bit_cnt, sync_err
    );

    modport slave (
        input  ser_in, ser_valid, frame_start, par_ready,
        output ser_ready, par_data, par_valid, bit_cnt, sync_err
    );
endinterface

// File: rtl/sipo_out_stage.sv
// One-entry valid/ready holding register; a load in the same cycle as a
// transfer replaces the word and keeps valid high.
module sipo_out_stage import sipo_pkg::*; #(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             par_ready,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    output logic             full
);
    out_state_e       state_r;
    logic [WIDTH-1:0] data_r;

    // Holding register state and captured word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= OUT_EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                OUT_EMPTY: begin
                    if (load) begin
                        state_r <= OUT_FULL;
                        data_r  <= data;
                    end
                end
                OUT_FULL: begin
                    if (load) begin
                        data_r <= data;
                    end else if (par_ready) begin
                        state_r <= OUT_EMPTY;
                    end
                end
                default: begin
                    state_r <= OUT_EMPTY;
                end
            endcase
        end
    end

    assign par_data  = data_r;
    assign par_valid = (state_r == OUT_FULL);
    assign full      = (state_r == OUT_FULL);
endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles WIDTH accepted bits into a
// word and hands it to a one-entry holding register with frame resync.
module sipo_deser import sipo_pkg::*; #(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter int MSB_FIRST = 32'sd1
) (
    input logic       clk,
    input logic       reset,
    sipo_deser_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sh_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             sync_err_r;

    logic [CNT_W-1:0] eff_cnt_s;
    logic             last_s;
    logic             ser_ready_s;
    logic             s_acc_s;
    logic             load_s;
    logic             full_s;
    logic [WIDTH-1:0] sh_next_s;

    // A frame_start restarts counting at this bit; only the completing bit may stall.
    always_comb begin
        eff_cnt_s   = bus.frame_start ? {CNT_W{1'b0}} : bit_cnt_r;
        last_s      = (eff_cnt_s == CNT_W'(WIDTH - 32'sd1));
        ser_ready_s = !(last_s && full_s && !bus.par_ready);
        s_acc_s     = bus.ser_valid && ser_ready_s;
        load_s      = s_acc_s && last_s;
        sh_next_s   = WIDTH'(sipo_shift(64'(sh_r), bus.ser_in, (MSB_FIRST != 32'sd0), WIDTH));
    end

    // Shift register, partial-word counter and resync error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r       <= {WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            sync_err_r <= 1'b0;
        end else if (s_acc_s) begin
            sh_r       <= sh_next_s;
            bit_cnt_r  <= last_s ? {CNT_W{1'b0}} : (eff_cnt_s + CNT_W'(1));
            sync_err_r <= bus.frame_start && (bit_cnt_r != {CNT_W{1'b0}});
        end else begin
            sync_err_r <= 1'b0;
        end
    end

    sipo_out_stage #(.WIDTH(WIDTH)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .data      (sh_next_s),
        .par_ready (bus.par_ready),
        .par_data  (bus.par_data),
        .par_valid (bus.par_valid),
        .full      (full_s)
    );

    assign bus.ser_ready = ser_ready_s;
    assign bus.bit_cnt   = bit_cnt_r;
    assign bus.sync_err  = sync_err_r;
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a queue-based word-assembly model.
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) bus_m ();
    sipo_deser_if #(.WIDTH(W)) bus_l ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .reset(reset), .bus(bus_m.slave));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .reset(reset), .bus(bus_l.slave));

    logic         got_rdy  [2];
    logic         got_vld  [2];
    logic [W-1:0] got_data [2];
    logic [1:0]   got_cnt  [2];
    logic         got_err  [2];

    assign got_rdy[0]  = bus_m.ser_ready;
    assign got_rdy[1]  = bus_l.ser_ready;
    assign got_vld[0]  = bus_m.par_valid;
    assign got_vld[1]  = bus_l.par_valid;
    assign got_data[0] = bus_m.par_data;
    assign got_data[1] = bus_l.par_data;
    assign got_cnt[0]  = bus_m.bit_cnt;
    assign got_cnt[1]  = bus_l.bit_cnt;
    assign got_err[0]  = bus_m.sync_err;
    assign got_err[1]  = bus_l.sync_err;

    // Reference model: bits of the current word in arrival order, plus the held word.
    bit           part_q [2][$];
    logic [W-1:0] m_word [2];
    logic         m_vld  [2];
    logic         m_err  [2];
    logic         m_rdy  [2];
    logic         seen_rdy [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int d, input logic rst, input logic v, input logic b,
                              input logic fs, input logic pr);
        logic         xfer;
        logic [W-1:0] w;
        if (rst) begin
            part_q[d].delete();
            m_word[d] = '0;
            m_vld[d]  = 1'b0;
            m_err[d]  = 1'b0;
        end else begin
            xfer     = m_vld[d] && pr;
            m_err[d] = 1'b0;
            if (v && m_rdy[d]) begin
                if (fs) begin
                    m_err[d] = (part_q[d].size() != 0);
                    part_q[d].delete();
                end
                part_q[d].push_back(b);
            end
            if (part_q[d].size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) begin
                    if (d == 0) w[W-1-i] = part_q[d][i];
                    else        w[i]     = part_q[d][i];
                end
                m_word[d] = w;
                m_vld[d]  = 1'b1;
                part_q[d].delete();
            end else if (xfer) begin
                m_vld[d] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic b, input logic fs, input logic pr);
        int eff;
        @(negedge clk);
        reset = rst;
        bus_m.ser_valid = v; bus_m.ser_in = b; bus_m.frame_start = fs; bus_m.par_ready = pr;
        bus_l.ser_valid = v; bus_l.ser_in = b; bus_l.frame_start = fs; bus_l.par_ready = pr;
        #1;
        for (int d = 0; d < 2; d++) begin
            eff = fs ? 0 : part_q[d].size();
            m_rdy[d] = !((eff == W - 1) && m_vld[d] && !pr);
            seen_rdy[d] = got_rdy[d];
            if (!rst) check($sformatf("ser_ready[%0d]", d), 32'(got_rdy[d]), 32'(m_rdy[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d, rst, v, b, fs, pr);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("par_valid[%0d]", d), 32'(got_vld[d]), 32'(m_vld[d]));
            check($sformatf("par_data[%0d]", d), 32'(got_data[d]), 32'(m_word[d]));
            check($sformatf("bit_cnt[%0d]", d), 32'(got_cnt[d]), 32'(part_q[d].size()));
            check($sformatf("sync_err[%0d]", d), 32'(got_err[d]), 32'(m_err[d]));
        end
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input logic pr);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, bits[i], 1'b0, pr);
    endtask

    initial begin
        reset = 1'b1;
        bus_m.ser_valid = 1'b0; bus_m.ser_in = 1'b0; bus_m.frame_start = 1'b0; bus_m.par_ready = 1'b0;
        bus_l.ser_valid = 1'b0; bus_l.ser_in = 1'b0; bus_l.frame_start = 1'b0; bus_l.par_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_word[d] = '0; m_vld[d] = 1'b0; m_err[d] = 1'b0; m_rdy[d] = 1'b1;
        end

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", 32'(got_vld[0]), 32'd0);
        check("rst_cnt", 32'(got_cnt[0]), 32'd0);

        // Basic word in both bit orders.
        send_bits(8'b0000_1011, 4, 1'b1);
        check("t1_valid", 32'(got_vld[0]), 32'd1);
        check("t1_word_msb", 32'(got_data[0]), 32'h0000_000B);
        check("t1_word_lsb", 32'(got_data[1]), 32'h0000_000D);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_one_cycle", 32'(got_vld[0]), 32'd0);

        // Backpressure: second word's final bit stalls until the first drains.
        send_bits(8'b0000_1011, 4, 1'b0);
        send_bits(8'b0000_0011, 3, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_stall_rdy", 32'(seen_rdy[0]), 32'd0);
        check("bp_stall_cnt", 32'(got_cnt[0]), 32'd3);
        check("bp_held", 32'(got_data[0]), 32'h0000_000B);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("bp_release_rdy", 32'(seen_rdy[0]), 32'd1);
        check("bp_next_word", 32'(got_data[0]), 32'h0000_0006);
        check("bp_no_bubble", 32'(got_vld[0]), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Resync mid-word.
        send_bits(8'b0000_0011, 2, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("sync_err_pulse", 32'(got_err[0]), 32'd1);
        send_bits(8'b0000_0101, 3, 1'b1);
        check("sync_err_once", 32'(got_err[0]), 32'd0);
        check("sync_word", 32'(got_data[0]), 32'h0000_0005);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset discards a partial word.
        send_bits(8'b0000_0011, 2, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_cnt", 32'(got_cnt[0]), 32'd0);
        send_bits(8'b0000_0011, 4, 1'b1);
        check("rst_mid_word", 32'(got_data[0]), 32'h0000_0003);

        // Continuous stream of two words.
        send_bits(8'b1010_0110, 4, 1'b1);
        send_bits(8'b1010_0110, 4, 1'b1);
        check("stream_word2", 32'(got_data[0]), 32'h0000_0006);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
